// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Interlock and flush controller for the five-stage stall pipeline (no
// forwarding). It watches the instruction sitting in ID against a small
// scoreboard of register writes still in flight (EX, MEM, WB) and against
// branches resolved in EX.
//
// It does three jobs:
//   - Stalls on a RAW hazard by holding PC and IF/ID and inserting a bubble
//     into ID/EX.
//   - Flushes when a branch in EX is taken. Prediction is not-taken, so the
//     wrong-path instruction in IF/ID is replaced by a NOP, the ID/EX
//     register gets a bubble, and the PC is loaded with the branch target.
//   - Counts stall cycles and taken-branch flushes in saturating counters.
//
// Parameters
//   WB_BYPASS  1: the register file writes in the first half-cycle, so a
//                 writer in WB is already visible to ID and is not compared.
//              0: the WB slot takes part in the hazard compare.
//   CNT_W      Width of the performance counters.
//
// Ports
//   clk, rst_n       Clock and asynchronous active-low reset.
//   id_valid         ID holds a real instruction.
//   id_rs, id_rt     Source registers of the ID instruction.
//   id_use_rs/rt     The ID instruction actually reads rs / rt.
//   id_wreg          The ID instruction writes a register.
//   id_destR         Destination register of the ID instruction.
//   ex_branch        EX holds a branch.
//   ex_zero          EX compare result (branch condition met).
//   pc_we            PC write enable.
//   ifid_we          IF/ID write enable.
//   ifid_flush       Load a NOP into IF/ID.
//   idex_bubble      Force wreg/wmem/branch to 0 in ID/EX.
//   pc_sel_branch    Select the branch target for the next PC.
//   stall_cnt        Total RAW stall cycles (saturating).
//   flush_cnt        Total taken-branch flushes (saturating).
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic [4:0]       id_destR,
  input  logic             ex_branch,
  input  logic             ex_zero,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_sel_branch,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Controller state.
  state_t state_q, state_d;

  // Scoreboard slots. Each slot records one in-flight writer: a valid bit and
  // its destination register.
  logic       ex_v_q,     ex_v_d;
  logic [4:0] ex_dest_q,  ex_dest_d;
  logic       mem_v_q,    mem_v_d;
  logic [4:0] mem_dest_q, mem_dest_d;
  logic       wb_v_q,     wb_v_d;
  logic [4:0] wb_dest_q,  wb_dest_d;

  // Performance counters.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Internal decode signals.
  logic taken;
  logic id_live;
  logic hit_rs;
  logic hit_rt;
  logic raw;

  // Unqualified output decisions. Reset forcing is applied on top of these.
  logic pc_we_c;
  logic ifid_we_c;
  logic ifid_flush_c;
  logic idex_bubble_c;
  logic pc_sel_branch_c;
  logic stall_inc;
  logic flush_inc;

  // The branch outcome is not-taken predicted, so only a taken branch acts.
  assign taken = ex_branch & ex_zero;

  // During FLUSH the ID stage holds the NOP that was loaded by the flush.
  // Whatever the upstream logic still shows on id_valid is ignored.
  assign id_live = id_valid & (state_q != FLUSH);

  // Compare each source against every in-flight writer. Register 0 is
  // hardwired, so it never creates a dependency. The WB slot only takes part
  // when the register file cannot bypass the write to the read in the same
  // cycle.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    if (id_rs != 5'd0) begin
      hit_rs = (ex_v_q  && (ex_dest_q  == id_rs)) ||
               (mem_v_q && (mem_dest_q == id_rs)) ||
               (!WB_BYPASS && wb_v_q && (wb_dest_q == id_rs));
    end
    if (id_rt != 5'd0) begin
      hit_rt = (ex_v_q  && (ex_dest_q  == id_rt)) ||
               (mem_v_q && (mem_dest_q == id_rt)) ||
               (!WB_BYPASS && wb_v_q && (wb_dest_q == id_rt));
    end
  end

  assign raw = id_live & ((id_use_rs & hit_rs) | (id_use_rt & hit_rt));

  // Next-state and output decision.
  //
  // A taken branch wins over a RAW stall. The instruction in ID is on the
  // wrong path in that case, so there is nothing to wait for: it is flushed,
  // and the cycle is not counted as a stall. Because raw is already masked
  // in FLUSH, the stall branch can never fire from FLUSH.
  always_comb begin
    state_d         = RUN;
    pc_we_c         = 1'b1;
    ifid_we_c       = 1'b1;
    ifid_flush_c    = 1'b0;
    idex_bubble_c   = 1'b0;
    pc_sel_branch_c = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (taken) begin
      pc_sel_branch_c = 1'b1;
      ifid_flush_c    = 1'b1;
      idex_bubble_c   = 1'b1;
      flush_inc       = 1'b1;
      state_d         = FLUSH;
    end else if (raw) begin
      pc_we_c       = 1'b0;
      ifid_we_c     = 1'b0;
      idex_bubble_c = 1'b1;
      stall_inc     = 1'b1;
      state_d       = STALL;
    end
  end

  // Scoreboard shift and counter updates.
  //
  // The slots shift every cycle, including stall cycles. A bubble enters EX
  // whenever ID/EX is bubbled, which keeps the slots aligned with what the
  // datapath actually carries. A writer to r0 is never recorded.
  always_comb begin
    ex_v_d     = 1'b0;
    ex_dest_d  = 5'd0;
    if (!idex_bubble_c) begin
      ex_v_d    = id_live & id_wreg & (id_destR != 5'd0);
      ex_dest_d = id_destR;
    end
    mem_v_d    = ex_v_q;
    mem_dest_d = ex_dest_q;
    wb_v_d     = mem_v_q;
    wb_dest_d  = mem_dest_q;

    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State register. Reset drops any pending stall or flush and empties the
  // scoreboard, so the first instruction after reset is checked against
  // nothing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ex_v_q      <= 1'b0;
      ex_dest_q   <= 5'd0;
      mem_v_q     <= 1'b0;
      mem_dest_q  <= 5'd0;
      wb_v_q      <= 1'b0;
      wb_dest_q   <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_v_q      <= ex_v_d;
      ex_dest_q   <= ex_dest_d;
      mem_v_q     <= mem_v_d;
      mem_dest_q  <= mem_dest_d;
      wb_v_q      <= wb_v_d;
      wb_dest_q   <= wb_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held the pipeline must free-run with no bubble or
  // redirect, even if a branch input happens to be high.
  assign pc_we         = pc_we_c | ~rst_n;
  assign ifid_we       = ifid_we_c | ~rst_n;
  assign ifid_flush    = ifid_flush_c & rst_n;
  assign idex_bubble   = idex_bubble_c & rst_n;
  assign pc_sel_branch = pc_sel_branch_c & rst_n;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Drives two controllers from the same inputs:
//   dut0  WB_BYPASS=1, CNT_W=16
//   dut1  WB_BYPASS=0, CNT_W=5   (small counters so saturation is reachable)
//
// A reference model predicts every output for every cycle. It keeps, per
// register, the cycle in which its last writer left ID, and it treats a
// register as busy while that writer is still inside the compare window.
// Expectations are queued, and a negedge monitor checks them against the DUT
// outputs.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       idValid = 1'b0;
  logic [4:0] idRs = '0;
  logic [4:0] idRt = '0;
  logic       useRs = 1'b0;
  logic       useRt = 1'b0;
  logic       idWreg = 1'b0;
  logic [4:0] idDest = '0;
  logic       exBranch = 1'b0;
  logic       exZero = 1'b0;

  logic        pcWe0, ifidWe0, ifidFlush0, idexBubble0, pcSel0;
  logic [15:0] stallCnt0, flushCnt0;
  logic        pcWe1, ifidWe1, ifidFlush1, idexBubble1, pcSel1;
  logic [4:0]  stallCnt1, flushCnt1;

  hazard_stall_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_wreg(idWreg), .id_destR(idDest),
    .ex_branch(exBranch), .ex_zero(exZero), .pc_we(pcWe0), .ifid_we(ifidWe0),
    .ifid_flush(ifidFlush0), .idex_bubble(idexBubble0),
    .pc_sel_branch(pcSel0), .stall_cnt(stallCnt0), .flush_cnt(flushCnt0));

  hazard_stall_ctrl #(.WB_BYPASS(1'b0), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs(idRs), .id_rt(idRt),
    .id_use_rs(useRs), .id_use_rt(useRt), .id_wreg(idWreg), .id_destR(idDest),
    .ex_branch(exBranch), .ex_zero(exZero), .pc_we(pcWe1), .ifid_we(ifidWe1),
    .ifid_flush(ifidFlush1), .idex_bubble(idexBubble1),
    .pc_sel_branch(pcSel1), .stall_cnt(stallCnt1), .flush_cnt(flushCnt1));

  typedef struct packed {
    logic        pcWe;
    logic        ifidWe;
    logic        ifidFlush;
    logic        idexBubble;
    logic        pcSel;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
  } expT;

  expT q0[$];
  expT q1[$];

  int checks = 0;
  int passes = 0;

  // Reference model state, one entry per DUT.
  int window[2] = '{2, 3};
  int cntMax[2] = '{65535, 31};
  int stallM[2];
  int flushM[2];
  bit inFlush[2];
  int lastWrite[2][32];
  int now = 0;

  // Compare one value and record the result.
  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Compare all outputs of one DUT against a queued expectation.
  task automatic checkOutput(input string tag, input expT e, input logic pcWe,
                             input logic ifidWe, input logic ifidFlush,
                             input logic idexBubble, input logic pcSel,
                             input int stallCnt, input int flushCnt);
    checkValue({tag, ".pc_we"}, int'(pcWe), int'(e.pcWe));
    checkValue({tag, ".ifid_we"}, int'(ifidWe), int'(e.ifidWe));
    checkValue({tag, ".ifid_flush"}, int'(ifidFlush), int'(e.ifidFlush));
    checkValue({tag, ".idex_bubble"}, int'(idexBubble), int'(e.idexBubble));
    checkValue({tag, ".pc_sel_branch"}, int'(pcSel), int'(e.pcSel));
    checkValue({tag, ".stall_cnt"}, stallCnt, int'(e.stallCnt));
    checkValue({tag, ".flush_cnt"}, flushCnt, int'(e.flushCnt));
  endtask

  function automatic bit busy(input int k, input logic [4:0] r);
    int age;
    age = now - lastWrite[k][r];
    return (r != 5'd0) && (age >= 1) && (age <= window[k]);
  endfunction

  // Predict this cycle's outputs. The counters shown are those accumulated
  // before this cycle.
  task automatic modelCycle(input int k, output expT e);
    bit vld, raw, taken;
    e = '0;
    e.pcWe = 1'b1;
    e.ifidWe = 1'b1;
    if (!rst_n) begin
      stallM[k] = 0;
      flushM[k] = 0;
      inFlush[k] = 1'b0;
      for (int r = 0; r < 32; r++) lastWrite[k][r] = -100;
      return;
    end
    e.stallCnt = 16'(stallM[k]);
    e.flushCnt = 16'(flushM[k]);
    taken = exBranch && exZero;
    vld = idValid && !inFlush[k];
    raw = vld && ((useRs && busy(k, idRs)) || (useRt && busy(k, idRt)));
    if (taken) begin
      e.pcSel = 1'b1;
      e.ifidFlush = 1'b1;
      e.idexBubble = 1'b1;
      if (flushM[k] < cntMax[k]) flushM[k]++;
      inFlush[k] = 1'b1;
    end else if (raw) begin
      e.pcWe = 1'b0;
      e.ifidWe = 1'b0;
      e.idexBubble = 1'b1;
      if (stallM[k] < cntMax[k]) stallM[k]++;
      inFlush[k] = 1'b0;
    end else begin
      inFlush[k] = 1'b0;
      if (vld && idWreg && idDest != 5'd0) lastWrite[k][idDest] = now;
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // predicted response.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic wreg, input logic [4:0] dest,
                               input logic br, input logic zero);
    expT e0, e1;
    @(posedge clk);
    #1;
    rst_n = rst;
    idValid = vld;
    idRs = rs;
    idRt = rt;
    useRs = urs;
    useRt = urt;
    idWreg = wreg;
    idDest = dest;
    exBranch = br;
    exZero = zero;
    modelCycle(0, e0);
    modelCycle(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    now++;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
  endtask

  // Monitor: outputs are valid every cycle; check them mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput("dut0", e, pcWe0, ifidWe0, ifidFlush0, idexBubble0, pcSel0,
                    int'(stallCnt0), int'(flushCnt0));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("dut1", e, pcWe1, ifidWe1, ifidFlush1, idexBubble1, pcSel1,
                    int'(stallCnt1), int'(flushCnt1));
      end
    end
  end

  initial begin
    int drain;
    for (int k = 0; k < 2; k++) begin
      stallM[k] = 0;
      flushM[k] = 0;
      inFlush[k] = 1'b0;
      for (int r = 0; r < 32; r++) lastWrite[k][r] = -100;
    end
    #2;
    checkValue("reset.pc_we", int'(pcWe0), 1);
    checkValue("reset.idex_bubble", int'(idexBubble0), 0);
    checkValue("reset.stall_cnt", int'(stallCnt0), 0);
    doReset();

    // Back-to-back producer r1 / consumer r1.
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    idle();
    #2;
    checkValue("raw.bypass_stall_cnt", int'(stallCnt0), 2);
    checkValue("raw.nobypass_stall_cnt", int'(stallCnt1), 3);

    // r0 never causes a hazard.
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    #2;
    checkValue("r0.pc_we", int'(pcWe1), 1);
    idle();
    #2;
    checkValue("r0.stall_cnt", int'(stallCnt1), 0);

    // Taken branch while ID has a RAW hazard.
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    #2;
    checkValue("taken.pc_sel_branch", int'(pcSel0), 1);
    checkValue("taken.ifid_flush", int'(ifidFlush0), 1);
    checkValue("taken.idex_bubble", int'(idexBubble0), 1);
    checkValue("taken.pc_we", int'(pcWe0), 1);
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #2;
    checkValue("flush.no_stall_pc_we", int'(pcWe1), 1);
    checkValue("flush.flush_cnt", int'(flushCnt0), 1);
    checkValue("flush.stall_cnt", int'(stallCnt0), 0);

    // Not-taken branch: pipeline keeps moving.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'(8 + i), 1'b1, 1'b0);
      #2;
      checkValue("nottaken.pc_we", int'(pcWe0), 1);
      checkValue("nottaken.ifid_flush", int'(ifidFlush0), 0);
    end
    idle();
    #2;
    checkValue("nottaken.flush_cnt", int'(flushCnt0), 0);

    // Reset while stalled.
    doReset();
    applyStimulus(1'b1, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    #2;
    checkValue("rststall.pc_we", int'(pcWe1), 1);
    checkValue("rststall.idex_bubble", int'(idexBubble1), 0);
    checkValue("rststall.stall_cnt", int'(stallCnt1), 0);
    applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    #2;
    checkValue("rststall.reeval_pc_we", int'(pcWe1), 1);

    // Independent stream: sources and destinations never overlap.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 5'($urandom_range(10, 15)), 5'($urandom_range(10, 15)),
                    1'b1, 1'b1, 1'b1, 5'($urandom_range(20, 31)), 1'b0, 1'b0);
    end
    idle();
    #2;
    checkValue("indep.stall_cnt0", int'(stallCnt0), 0);
    checkValue("indep.stall_cnt1", int'(stallCnt1), 0);

    // Saturation on the narrow counters: self-dependent instruction stalls
    // repeatedly, then a run of taken branches.
    doReset();
    repeat (100) applyStimulus(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    repeat (40) applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    idle();
    #2;
    checkValue("sat.stall_cnt1", int'(stallCnt1), 31);
    checkValue("sat.flush_cnt1", int'(flushCnt1), 31);

    // Randomised traffic over a small register range to provoke hazards.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                    1'($urandom));
    end
    idle();

    drain = 0;
    while ((q0.size() > 0 || q1.size() > 0) && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Interlock and flush controller for the five-stage stall pipeline. It sequences the ID->EX boundary: holds PC and IF/ID, injects bubbles into the ID/EX register, and redirects/flushes on branches resolved in EX (ex_branch, ex_zero).
- Tracks in-flight register writes in an internal 3-slot scoreboard (EX, MEM, WB). No forwarding exists: any RAW hazard is resolved by stalling.

Parameters:
- WB_BYPASS, 1, 1 = register file writes in first half-cycle, so the WB slot is excluded from hazard compare; 0 = the WB slot is compared.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  5  source register 1 of the ID instruction
- id_rt  input  5  source register 2 of the ID instruction
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt
- id_wreg  input  1  ID instruction writes a register
- id_destR  input  5  destination register of the ID instruction (already muxed rt/rd)
- ex_branch  input  1  EX holds a branch
- ex_zero  input  1  EX compare result
- pc_we  output  1  PC write enable
- ifid_we  output  1  IF/ID write enable
- ifid_flush  output  1  load NOP into IF/ID
- idex_bubble  output  1  force wreg/wmem/branch=0 into ID/EX
- pc_sel_branch  output  1  select branch target (ex_pc) for PC
- stall_cnt  output  CNT_W  total stall cycles
- flush_cnt  output  CNT_W  total taken-branch flushes

Behaviour:
- Scoreboard slot = {v, dest[4:0]}. On each posedge: EX <= (idex_bubble ? 0 : {id_valid & id_wreg & (id_destR!=0), id_destR}); MEM <= EX; WB <= MEM. Slots shift even while stalled.
- hit(r) = (r!=0) & ((EX.v & EX.dest==r) | (MEM.v & MEM.dest==r) | (!WB_BYPASS & WB.v & WB.dest==r)).
- raw = id_valid & ((id_use_rs & hit(id_rs)) | (id_use_rt & hit(id_rt))). Combinational.
- taken = ex_branch & ex_zero. Branch prediction is not-taken.
- FSM states: RUN, STALL, FLUSH. Reset -> RUN.
- Outputs are combinational from state and inputs. Priority: taken > raw.
  - taken (any state): pc_sel_branch=1, pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1; next state FLUSH.
  - else raw and state!=FLUSH: pc_we=0, ifid_we=0, idex_bubble=1; next state STALL.
  - else: pc_we=1, ifid_we=1, others 0; next state RUN.
- FLUSH lasts exactly one cycle. During FLUSH, ID holds the flushed NOP: raw is ignored and id_valid is treated as 0. FLUSH -> RUN unless taken is asserted again.
- STALL -> RUN when raw clears; STALL holds while raw stays set.
- Counters: stall_cnt increments in every cycle where the raw-stall branch is taken. flush_cnt increments once per taken. Both saturate at all-ones; no wrap.
- Reset (asynchronous, any time including mid-stall/flush): state=RUN, all slots invalid, counters=0.
  - Outputs under reset: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0, pc_sel_branch=0.
  - Any pending stall or flush is discarded.
- Register 0 never causes a hazard.
- A stalled instruction that is simultaneously on the wrong path of a taken branch is flushed, not stalled. No stall count is taken that cycle.

Test Plan:
- Reset mid-STALL (rst_n low one cycle) -> counters 0, pc_we=1, idex_bubble=0 immediately; the next dependent instruction re-evaluates from an empty scoreboard.
- Producer add r1 then consumer add r3,r1,r2 back-to-back, WB_BYPASS=1 -> pc_we=0/idex_bubble=1 for exactly 2 cycles, stall_cnt=2. With WB_BYPASS=0 -> 3 cycles, stall_cnt=3.
- Producer writes r0, consumer reads r0 -> no stall, stall_cnt=0.
- beq in EX with ex_zero=1 while ID has a raw hazard -> single cycle with pc_sel_branch=1, ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1; stall_cnt unchanged; next cycle in FLUSH with no stall.
- beq with ex_zero=0 -> no flush, no bubble, flush_cnt=0, pipeline advances every cycle.
- Independent stream (rs/rt never match in-flight dests) for 20 cycles -> pc_we=1 every cycle, counters 0. Force stall_cnt near all-ones and stall -> it holds at 0xFFFF.
